// File: rtl/chunk_add_sequencer.sv
// Multi-cycle W-bit add/subtract built from a single 3-bit carry-lookahead adder.
// One 3-bit chunk is processed per cycle, least significant chunk first.

module cla3 (
  input  logic [2:0] i_a,
  input  logic [2:0] i_b,
  input  logic       i_c,
  output logic [2:0] o_s,
  output logic       o_c
);
  logic [2:0] w_g;
  logic [2:0] w_p;
  logic [2:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign o_c    = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign o_s    = w_p ^ w_c;
endmodule

// state | meaning
// IDLE  | waiting for start; result outputs hold the last result
// RUN   | one chunk added per cycle, busy=1
// DONE  | result valid, done=1 for this single cycle
module chunk_add_sequencer #(
  parameter  int CHUNKS = 4,
  localparam int W      = 3 * CHUNKS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         overflow
);
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic [IDX_W-1:0] r_idx;
  logic             w_accept;
  logic             w_last;
  logic [2:0]       w_s;
  logic             w_c;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_idx == LAST);

  cla3 u_cla3 (
    .i_a (r_x[2:0]),
    .i_b (r_y[2:0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operands rotate and the sum shifts in from the top, so the active chunk
  // always sits in bits [2:0]; after CHUNKS steps every chunk is back in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_x     <= x;
      r_y     <= y ^ {W{sub}};
      r_carry <= sub;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_x     <= (r_x >> 3) | (r_x << (W - 3));
      r_y     <= (r_y >> 3) | (r_y << (W - 3));
      r_sum   <= (r_sum >> 3) | (W'(w_s) << (W - 3));
      r_carry <= w_c;
      r_idx   <= r_idx + 1'b1;
      if (w_last) r_ovf <= (r_x[2] == r_y[2]) && (w_s[2] != r_x[2]);
    end
  end

  assign sum      = r_sum;
  assign c_out    = r_carry;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_chunk_add_sequencer.sv
// Randomised and directed scoreboard bench for chunk_add_sequencer (CHUNKS=4).
// Driver pushes expected results; a negedge monitor pops them when done pulses.

module tb_chunk_add_sequencer;
  localparam int CHUNKS = 4;
  localparam int W      = 3 * CHUNKS;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  exp_t q[$];
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   done_cnt  = 0;
  int   busy_len  = 0;
  bit   aborted   = 0;

  chunk_add_sequencer #(.CHUNKS(CHUNKS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa, sb, r;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    if (s) begin
      e.sum = W'(a - b);
      e.c   = (a >= b);
      r     = sa - sb;
    end else begin
      {e.c, e.sum} = {1'b0, a} + {1'b0, b};
      r     = sa + sb;
    end
    e.v   = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    e.cyc = 0;
    return e;
  endfunction

  task automatic push(input logic [W-1:0] s, input logic c, input logic v, input int at);
    exp_t e;
    e.sum = s; e.c = c; e.v = v; e.cyc = at;
    q.push_back(e);
  endtask

  // Called at posedge+2; start is sampled at the next edge.
  task automatic issue_d(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] es, input logic ec, input logic ev);
    x = a; y = b; sub = s; start = 1'b1;
    push(es, ec, ev, cyc + 1 + CHUNKS);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e = model(a, b, s);
    issue_d(a, b, s, e.sum, e.c, e.v);
  endtask

  // Drains the scoreboard while scrambling the inputs; returns at posedge+2.
  task automatic wait_idle();
    for (int i = 0; i < 64 && q.size() != 0; i++) begin
      @(posedge clk); #2;
      x = W'($urandom); y = W'($urandom); sub = 1'($urandom);
    end
    check("drain_timeout", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (busy) begin
      busy_len++;
      if (reset) aborted = 1;
    end else if (busy_len != 0) begin
      if (!aborted) check("busy_len", busy_len, CHUNKS);
      busy_len = 0;
      aborted  = 0;
    end
    if (done) begin
      done_cnt++;
      if (q.size() == 0) check("spurious_done", done, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("sum", sum, e.sum);
        check("c_out", c_out, e.c);
        check("overflow", overflow, e.v);
        check("done_cycle", cyc, e.cyc);
        check("busy_in_done", busy, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int first_cyc;
    reset = 1'b1; start = 1'b0; sub = 1'b0; x = '0; y = '0;
    @(posedge clk); @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #2;

    // First start coincides with the first edge where reset is low.
    reset = 1'b0;
    issue_d(12'h0FF, 12'h001, 1'b0, 12'h100, 1'b0, 1'b0); wait_idle();
    issue_d(12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0); wait_idle();
    issue_d(12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1); wait_idle();

    // Reset during chunk 2 of a subtract; overflow from the prior op is still 1.
    issue(12'h555, 12'h222, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    void'(q.pop_back());
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_c_out", c_out, 0);
    check("abort_overflow", overflow, 0);
    @(posedge clk); #2;
    issue_d(12'h123, 12'h111, 1'b0, 12'h234, 1'b0, 1'b0); wait_idle();

    issue_d(12'h005, 12'h007, 1'b1, 12'hFFE, 1'b0, 1'b0); wait_idle();
    issue_d(12'h007, 12'h005, 1'b1, 12'h002, 1'b1, 1'b0); wait_idle();

    // Start pulsed mid-RUN with other operands must be ignored.
    d0 = done_cnt;
    issue_d(12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0);
    @(posedge clk); #2;
    x = 12'hABC; y = 12'h111; sub = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();
    check("ignored_start_dones", done_cnt - d0, 1);

    // Back-to-back: start held through DONE, operands switched while RUN.
    x = 12'h003; y = 12'h004; sub = 1'b0; start = 1'b1;
    first_cyc = cyc + 1 + CHUNKS;
    push(12'h007, 1'b0, 1'b0, first_cyc);
    push(12'h002, 1'b0, 1'b0, first_cyc + CHUNKS + 1);
    @(posedge clk); #2;
    x = 12'h001; y = 12'h001;
    for (int i = 0; i < 20 && q.size() > 1; i++) begin
      @(posedge clk); #2;
    end
    start = 1'b0;
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      wait_idle();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(posedge clk); #2;
      end
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/chunk_add_sequencer.md
CHUNK_ADD_SEQUENCER -- requirements
Module: chunk_add_sequencer

Interface
REQ-001 Parameter: CHUNKS, default 4, number of 3-bit chunks per operand; operand width W = 3*CHUNKS; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 start  input  1  request to begin an operation; sampled only when the block is ready to accept.
REQ-005 sub  input  1  0 = x+y, 1 = x-y; captured with start.
REQ-006 x  input  W  first operand; captured with start.
REQ-007 y  input  W  second operand; captured with start.
REQ-008 busy  output  1  high while chunks are being processed.
REQ-009 done  output  1  one-cycle pulse when sum, c_out and overflow are valid.
REQ-010 sum  output  W  result, registered.
REQ-011 c_out  output  1  carry out of bit W-1; for sub, 1 = no borrow (x >= y unsigned).
REQ-012 overflow  output  1  two's-complement overflow of the W-bit result.

Function
REQ-013 The block shall contain exactly one instance of the team's 3-bit carry-lookahead adder, and all arithmetic shall go through it, one chunk per cycle.
REQ-014 FSM states: IDLE, RUN, DONE; encoding free; no other reachable states.
REQ-015 Start acceptance: start=1 in IDLE or DONE latches x, y^{W{sub}}, sub. It also sets the carry register to sub, sets chunk index to 0 and moves to RUN.
REQ-016 RUN, each cycle with index i:
- Adder inputs: x_reg[3i+2:3i], y_reg[3i+2:3i], carry register.
- Adder output is written to sum[3i+2:3i].
- Adder carry out is loaded into the carry register.
- Index increments by 1.
REQ-017 RUN with i = CHUNKS-1 shall transition to DONE; otherwise remain in RUN.
REQ-018 Latency: start sampled at edge T puts the block in RUN from T through T+CHUNKS-1 edges. DONE is entered at edge T+CHUNKS, and done=1 during that following cycle (CHUNKS+1 cycles after the start cycle).
REQ-019 busy=1 exactly while state is RUN; done=1 exactly while state is DONE.
REQ-020 start=1 during RUN shall be ignored: no operand capture, no state change.
REQ-021 DONE with start=0 shall return to IDLE next cycle; DONE with start=1 shall behave per REQ-015 (back-to-back, no IDLE cycle).
REQ-022 Changes on x, y or sub after capture shall not affect the running operation.
REQ-023 c_out shall equal the carry register after the last chunk. It is valid from the DONE cycle and held until the next accepted start.
REQ-024 overflow shall be (x_reg[W-1] == y_reg[W-1]) && (sum[W-1] != x_reg[W-1]), using the possibly inverted y_reg. It is valid from the DONE cycle and held until the next accepted start.
REQ-025 sum shall hold its final value in IDLE and DONE, and until overwritten chunk-by-chunk in the next RUN; sum bits are undefined for checking while busy=1.
REQ-026 All arithmetic shall be modulo 2^W; no saturation.

Reset
REQ-027 reset=1 at a rising edge shall force: state IDLE, index 0, carry register 0, sum 0, c_out 0, overflow 0, busy 0, done 0.
REQ-028 Reset shall take priority over start and over any in-progress RUN; an aborted operation produces no done pulse.
REQ-029 The first start shall be accepted at the first edge where reset=0.

Verification
REQ-030 Directed scenarios the bench shall cover (CHUNKS=4, W=12):
- Add: x=0x0FF, y=0x001, sub=0 -> done after 5 cycles, busy high 4 cycles, sum=0x100, c_out=0, overflow=0.
- Wrap and carry: x=0xFFF, y=0x001, sub=0 -> sum=0x000, c_out=1, overflow=0.
- Signed overflow: x=0x7FF, y=0x001, sub=0 -> sum=0x800, c_out=0, overflow=1.
- Subtract with borrow: x=0x005, y=0x007, sub=1 -> sum=0xFFE, c_out=0, overflow=0.
- Subtract, no borrow: x=0x007, y=0x005, sub=1 -> sum=0x002, c_out=1, overflow=0.
- Busy start is ignored: start pulsed mid-RUN with different operands -> result unchanged, exactly one done pulse.
- Back-to-back: start held through DONE with 0x001+0x001 -> second done 5 cycles after the first, sum=0x002.
- Reset mid-RUN: reset asserted during chunk 2 -> next cycle all outputs 0, no done pulse; a following start of 0x123+0x111 -> sum=0x234.
